// File: rtl/branch_resolve_update_pkg.sv
// branch_resolve_update_pkg: opcodes, funct3 codes and the predictor update entry
package branch_resolve_update_pkg;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    // index_tag is pc[31:2] = {tag, index}; the top splits it at IDX_W so the entry stays width-independent
    typedef struct packed {
        logic [29:0] index_tag;
        logic [31:0] target;
        logic        taken;
        logic        btb_we;
    } upd_entry_t;
endpackage

// File: rtl/branch_resolve_update_if.sv
// branch_resolve_update_if: valid/ready write port into the BTB/BHT storage
interface branch_resolve_update_if #(parameter int IDX_W = 8);
    logic              upd_valid;
    logic              upd_ready;
    logic [IDX_W-1:0]  upd_index;
    logic [29-IDX_W:0] upd_tag;
    logic [31:0]       upd_target;
    logic              upd_taken;
    logic              upd_btb_we;
    modport master(output upd_valid, upd_index, upd_tag, upd_target, upd_taken, upd_btb_we, input upd_ready);
    modport slave(input upd_valid, upd_index, upd_tag, upd_target, upd_taken, upd_btb_we, output upd_ready);
endinterface

// File: rtl/upd_fifo.sv
// upd_fifo: first-word-fall-through sync FIFO; push into a full FIFO succeeds when a pop frees a slot
module upd_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;
    assign empty   = wp == rp;
    assign full    = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp[AW-1:0]];
    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= din;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop) rp <= rp + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/branch_resolve_update.sv
// branch_resolve_update: EX-stage branch resolution, redirect/flush and buffered predictor table update
module branch_resolve_update
    import branch_resolve_update_pkg::*;
#(
    parameter int IDX_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    input  logic [31:0]            ex_pc,
    input  logic [31:0]            ex_inst,
    input  logic                   ex_breq,
    input  logic                   ex_brlt,
    input  logic [31:0]            ex_alu,
    input  logic                   ex_pred_taken,
    input  logic [31:0]            ex_pred_target,
    output logic                   redirect_valid,
    output logic [31:0]            redirect_pc,
    output logic                   rs_IF_ID,
    output logic                   rs_ID_EX,
    branch_resolve_update_if.master upd,
    output logic [CNT_W-1:0]       stat_branches,
    output logic [CNT_W-1:0]       stat_mispred,
    output logic [CNT_W-1:0]       stat_dropped
);
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic        is_br, is_jalr, resolve, br_taken, taken, mispred, full, empty, pop;
    logic [31:0] target;
    upd_entry_t  din, dout;
    logic        unused_inst;
    assign opc         = ex_inst[6:2];
    assign f3          = ex_inst[14:12];
    assign unused_inst = ^{ex_inst[31:15], ex_inst[11:7], ex_inst[1:0]};
    always_comb begin
        is_br          = opc == OP_BRANCH && f3 != 3'd2 && f3 != 3'd3;
        is_jalr        = opc == OP_JALR;
        resolve        = ex_valid && (is_br || is_jalr || opc == OP_JAL);
        br_taken       = f3 == F3_BEQ ? ex_breq : f3 == F3_BNE ? !ex_breq : f3[0] ? !ex_brlt : ex_brlt;
        taken          = is_br ? br_taken : 1'b1;
        target         = is_jalr ? {ex_alu[31:1], 1'b0} : ex_alu;
        mispred        = resolve && (taken != ex_pred_taken || (taken && ex_pred_target != target));
        redirect_valid = mispred;
        rs_IF_ID       = mispred;
        rs_ID_EX       = mispred;
        redirect_pc    = mispred && taken ? target : ex_pc + 32'd4;
        din            = '{index_tag: ex_pc[31:2], target: target, taken: taken, btb_we: taken};
    end
    assign pop = upd.upd_valid && upd.upd_ready;
    upd_fifo #(.W($bits(upd_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk,
        .rst_n,
        .push(resolve),
        .pop,
        .din,
        .dout,
        .full,
        .empty
    );
    assign upd.upd_valid  = !empty;
    assign upd.upd_index  = dout.index_tag[IDX_W-1:0];
    assign upd.upd_tag    = dout.index_tag[29:IDX_W];
    assign upd.upd_target = dout.target;
    assign upd.upd_taken  = dout.taken;
    assign upd.upd_btb_we = dout.btb_we;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
            stat_dropped  <= '0;
        end else begin
            if (resolve && !(&stat_branches)) stat_branches <= stat_branches + CNT_W'(1);
            if (mispred && !(&stat_mispred)) stat_mispred <= stat_mispred + CNT_W'(1);
            if (resolve && full && !pop && !(&stat_dropped)) stat_dropped <= stat_dropped + CNT_W'(1);
        end
    end
endmodule

// File: doc/branch_resolve_update.md
Name: branch_resolve_update

Overview:
- Resolves each control-transfer instruction (BRANCH/JAL/JALR) when it reaches EX and compares the actual outcome with the prediction carried down the pipe from ID.
- Drives the redirect PC and the IF/ID and ID/EX flushes.
- Writes the resolved outcome into the prediction tables (BTB tag/target, BHT history) through a buffered valid/ready write port.
- Writer-side counterpart of the ID-stage predictor lookup; sits between the EX comparator/ALU and the predictor table storage.

Parameters:
IDX_W, 8, BTB/BHT index width; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]
FIFO_DEPTH, 4, update-queue entries (power of 2, >=2)
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  EX holds a live instruction this cycle (deasserted on bubble/stall)
ex_pc  in  32  PC of the EX instruction
ex_inst  in  32  instruction word in EX
ex_breq  in  1  comparator rs1==rs2
ex_brlt  in  1  comparator rs1<rs2 (signedness already chosen by funct3)
ex_alu  in  32  ALU result = computed target
ex_pred_taken  in  1  prediction made in ID for this instruction
ex_pred_target  in  32  predicted target made in ID
redirect_valid  out  1  fetch must restart at redirect_pc
redirect_pc  out  32  corrected fetch address
rs_IF_ID  out  1  flush IF/ID register
rs_ID_EX  out  1  flush ID/EX register
upd_valid  out  1  update entry available
upd_ready  in  1  table storage accepts entry
upd_index  out  IDX_W  table index
upd_tag  out  32-IDX_W-2  BTB tag
upd_target  out  32  resolved target
upd_taken  out  1  resolved direction (BHT shift-in / counter train)
upd_btb_we  out  1  write BTB tag/target (only for taken)
stat_branches  out  CNT_W  resolved control transfers
stat_mispred  out  CNT_W  redirects issued
stat_dropped  out  CNT_W  updates lost to full queue

Behaviour:
- Control transfer: ex_valid and opcode[6:2] in {11000 BRANCH, 11011 JAL, 11001 JALR}.
- Direction, BRANCH funct3: 0 beq = breq; 1 bne = !breq; 4/6 blt/bltu = brlt; 5/7 bge/bgeu = !brlt.
- funct3 2/3 (illegal): treated as not a control transfer. No redirect, no update, no stat change.
- JAL/JALR always taken. Actual target = ex_alu for BRANCH/JAL; ex_alu & ~1 for JALR.
- Mispredict (combinational, same cycle as EX):
  - if actual_taken != ex_pred_taken, or
  - if both taken and ex_pred_target != actual target.
- On mispredict: redirect_valid=1, rs_IF_ID=1, rs_ID_EX=1.
  - redirect_pc = actual target if taken, else ex_pc+4 (32-bit wrap).
  - Otherwise all three are 0 and redirect_pc = ex_pc+4 (don't-care).
- Update enqueue, registered: on the clock edge ending a resolving cycle, push {index, tag, target, taken, btb_we=taken}. Every resolved transfer is pushed, correct or not, so BHT history advances each time.
- Queue: FIFO_DEPTH entries, first-word-fall-through.
  - upd_* present the head entry. Pop when upd_valid && upd_ready.
  - Push and pop in the same cycle: allowed in any state. On a full queue, simultaneous pop frees the slot, so the push succeeds.
  - Full with no pop: the new update is dropped and stat_dropped increments. Redirect is unaffected; correctness never depends on the tables.
  - Empty: upd_valid=0, upd_* hold the last value (don't-care).
  - Pointers are IDX of log2(FIFO_DEPTH)+1 bits with wrap; the MSB distinguishes full from empty.
- Statistics: increment by 1 at the resolving edge and saturate at all-ones; no wrap.
- Reset (rst_n=0 at posedge):
  - queue emptied, all stats = 0, upd_valid = 0.
  - Combinational redirect outputs still follow inputs; the pipeline gates ex_valid during reset.
  - Reset mid-drain discards pending entries. An entry presented with upd_ready=1 in the reset cycle is not considered written.

Decomposition:
- Shared package: opcode constants (OP_BRANCH, OP_JAL, OP_JALR), funct3 constants, update-entry struct {index, tag, target, taken, btb_we}.
- One sub-module: upd_fifo (parameterized sync FIFO, width = entry width, depth FIFO_DEPTH, sync active-low reset).

Test Plan:
1. beq, breq=1, pred_taken=0, ex_alu=0x100, ex_pc=0x40:
   - same cycle: redirect_valid=1, redirect_pc=0x100, both flushes=1.
   - next cycle: upd_valid=1, index=0x10, taken=1, btb_we=1; stat_mispred=1.
2. bne, breq=1, pred_taken=1, ex_pc=0x80:
   - redirect_pc=0x84, flushes=1.
   - entry taken=0, btb_we=0.
3. jal, pred_taken=1, pred_target=0x200, ex_alu=0x200: no redirect, entry pushed, stat_branches+1, stat_mispred unchanged.
   - jalr, ex_alu=0x301, pred_target=0x300: no redirect.
4. upd_ready=0, 5 consecutive resolving branches: 4 queued, stat_dropped=1.
   - Then ready=1 with a simultaneous 6th branch: queue stays at 4, nothing further dropped.
   - Entries drain in order.
5. funct3=2 branch, or ex_valid=0 with a branch opcode: no redirect, no push, stats unchanged.
6. rst_n=0 with 3 entries queued and stats nonzero: next cycle upd_valid=0 and stats=0.
   - Saturation case: preload stat_mispred to all-ones; a further mispredict leaves it unchanged.
